// File: rtl/mem_bus_sched.sv
// Shared Memory data-bus scheduler: arbitrates USB-side writes and reads,
// owns bus direction, transfer strobe, turnaround cycles and buffer occupancy.
module mem_bus_sched #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int MAX_BURST = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_valid_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    output logic                         wr_ready_o,
    input  logic                         rd_req_i,
    output logic [DATA_W-1:0]            rd_data_o,
    output logic                         rd_valid_o,
    inout  wire  [DATA_W-1:0]            data_io,
    output logic                         tx_oe_o,
    output logic                         mem_en_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {IDLE, WRITE, W_TURN, READ, R_DRAIN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [BW-1:0]   burst, burst_nxt;
    logic            last_rd, last_rd_nxt;
    logic            rd_vld_p0;
    logic            wr_elig, rd_elig;

    function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] v);
        return (v == CW'(DEPTH)) ? v : v + CW'(1);
    endfunction

    function automatic logic [CW-1:0] dec_sat(input logic [CW-1:0] v);
        return (v == '0) ? v : v - CW'(1);
    endfunction

    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign tx_oe_o = (state != WRITE);
    assign data_io = (state == WRITE) ? wr_data_i : 'z;

    assign wr_elig = wr_valid_i & ~full_o;
    assign rd_elig = rd_req_i & ~empty_o;

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        burst_nxt   = burst;
        last_rd_nxt = last_rd;
        wr_ready_o  = 1'b0;
        mem_en_o    = 1'b0;
        case (state)
            IDLE: begin
                // On contention the direction not served last time wins.
                if (wr_elig && (!rd_elig || last_rd)) begin
                    state_nxt   = WRITE;
                    last_rd_nxt = 1'b0;
                    burst_nxt   = '0;
                end else if (rd_elig) begin
                    state_nxt   = READ;
                    last_rd_nxt = 1'b1;
                    burst_nxt   = '0;
                end
            end
            WRITE: begin
                wr_ready_o = ~full_o;
                if (wr_elig) begin
                    mem_en_o  = 1'b1;
                    count_nxt = inc_sat(count);
                    burst_nxt = burst + BW'(1);
                    if (burst_nxt == BW'(MAX_BURST) || count_nxt == CW'(DEPTH))
                        state_nxt = W_TURN;
                end else begin
                    state_nxt = W_TURN;
                end
            end
            W_TURN:  state_nxt = IDLE;
            READ: begin
                if (rd_elig) begin
                    mem_en_o  = 1'b1;
                    count_nxt = dec_sat(count);
                    burst_nxt = burst + BW'(1);
                    if (burst_nxt == BW'(MAX_BURST) || count_nxt == '0)
                        state_nxt = R_DRAIN;
                end else begin
                    state_nxt = R_DRAIN;
                end
            end
            R_DRAIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // p0: read request issued; p1: byte driven by Memory is captured.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            count      <= '0;
            burst      <= '0;
            last_rd    <= 1'b1;
            rd_vld_p0  <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            burst      <= burst_nxt;
            last_rd    <= last_rd_nxt;
            rd_vld_p0  <= mem_en_o & (state == READ);
            rd_valid_o <= rd_vld_p0;
            if (rd_vld_p0)
                rd_data_o <= data_io;
        end
    end
endmodule

// File: tb/tb_mem_bus_sched.sv
// Directed bench for mem_bus_sched with a small Memory model on the shared bus
// and a byte-order scoreboard for the contention scenario.
module tb_mem_bus_sched;
    logic       clk = 1'b0;
    logic       rst_i;
    logic       wr_valid_i;
    logic [7:0] wr_data_i;
    logic       wr_ready_o;
    logic       rd_req_i;
    logic [7:0] rd_data_o;
    logic       rd_valid_o;
    wire  [7:0] data_io;
    logic       tx_oe_o;
    logic       mem_en_o;
    logic [4:0] count_o;
    logic       full_o;
    logic       empty_o;

    int n_checks = 0;
    int n_errors = 0;

    mem_bus_sched #(.DATA_W(8), .DEPTH(16), .MAX_BURST(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i),
        .wr_ready_o(wr_ready_o), .rd_req_i(rd_req_i), .rd_data_o(rd_data_o),
        .rd_valid_o(rd_valid_o), .data_io(data_io), .tx_oe_o(tx_oe_o),
        .mem_en_o(mem_en_o), .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    // Memory model: stores written bytes, drives a requested byte from the
    // middle of the following cycle, otherwise drives an idle pattern.
    logic [7:0] mem [16];
    logic [7:0] mem_drv;
    logic       mem_pend;
    int         wp, rp;
    assign data_io = tx_oe_o ? mem_drv : 8'bz;

    always @(negedge clk) begin
        if (rst_i) begin
            wp <= 0; rp <= 0; mem_drv <= 8'h5A; mem_pend <= 1'b0;
        end else begin
            if (mem_en_o && !tx_oe_o) begin
                mem[wp] <= data_io;
                wp <= (wp + 1) % 16;
            end
            if (mem_pend) begin
                mem_drv <= mem[rp];
                rp <= (rp + 1) % 16;
            end else begin
                mem_drv <= 8'h5A;
            end
            mem_pend <= mem_en_o && tx_oe_o;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard of bytes written, consumed in order by rd_valid pulses.
    logic [7:0] exp_q [$];
    logic       mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_en_o && !tx_oe_o) exp_q.push_back(wr_data_i);
            if (rd_valid_o) begin
                if (exp_q.size() == 0) check_eq("rd_unexpected", 32'(rd_valid_o), 32'd0);
                else check_eq("rd_order", 32'(rd_data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    int  run_len [8];
    bit  run_w [8];
    int  nruns, cur_len;
    bit  cur_w;

    task automatic track_clear();
        nruns = 0; cur_len = 0; cur_w = 1'b0;
    endtask

    task automatic track(input bit w, input bit r);
        if (w || r) begin
            if (cur_len == 0) cur_w = w;
            cur_len++;
        end else if (cur_len > 0) begin
            if (nruns < 8) begin
                run_len[nruns] = cur_len;
                run_w[nruns]   = cur_w;
            end
            nruns++;
            cur_len = 0;
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        next_cyc();
        next_cyc();
        rst_i = 1'b0;
    endtask

    initial begin
        bit w, r;
        int acc, sent, viol, cyc, last_rd_cyc;
        rst_i = 1'b0; wr_valid_i = 1'b0; wr_data_i = 8'h00; rd_req_i = 1'b0;

        // Reset, then three back-to-back writes.
        do_reset();
        wr_valid_i = 1'b1; wr_data_i = 8'hAA;
        @(negedge clk);
        check_eq("rst_tx_oe", 32'(tx_oe_o), 32'd1);
        check_eq("rst_count", 32'(count_o), 32'd0);
        check_eq("rst_empty", 32'(empty_o), 32'd1);
        check_eq("rst_wr_ready", 32'(wr_ready_o), 32'd0);
        check_eq("rst_mem_en", 32'(mem_en_o), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid_o), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data_o), 32'd0);
        check_eq("rst_bus_released", 32'(data_io), 32'h5A);
        next_cyc();
        @(negedge clk);
        check_eq("w1_tx_oe", 32'(tx_oe_o), 32'd0);
        check_eq("w1_mem_en", 32'(mem_en_o), 32'd1);
        check_eq("w1_wr_ready", 32'(wr_ready_o), 32'd1);
        check_eq("w1_bus", 32'(data_io), 32'hAA);
        next_cyc(); wr_data_i = 8'hBB;
        @(negedge clk);
        check_eq("w2_bus", 32'(data_io), 32'hBB);
        check_eq("w2_count", 32'(count_o), 32'd1);
        next_cyc(); wr_data_i = 8'hCC;
        @(negedge clk);
        check_eq("w3_bus", 32'(data_io), 32'hCC);
        check_eq("w3_count", 32'(count_o), 32'd2);
        next_cyc(); wr_valid_i = 1'b0;
        @(negedge clk);
        check_eq("w_end_mem_en", 32'(mem_en_o), 32'd0);
        check_eq("w_end_count", 32'(count_o), 32'd3);
        next_cyc();
        @(negedge clk);
        check_eq("wturn_tx_oe", 32'(tx_oe_o), 32'd1);
        check_eq("wturn_wr_ready", 32'(wr_ready_o), 32'd0);
        check_eq("wturn_bus_released", 32'(data_io), 32'h5A);

        // Read the three bytes back.
        next_cyc(); rd_req_i = 1'b1;
        @(negedge clk);
        check_eq("ridle_mem_en", 32'(mem_en_o), 32'd0);
        next_cyc();
        @(negedge clk);
        check_eq("r1_mem_en", 32'(mem_en_o), 32'd1);
        check_eq("r1_tx_oe", 32'(tx_oe_o), 32'd1);
        check_eq("r1_count", 32'(count_o), 32'd3);
        next_cyc();
        @(negedge clk);
        check_eq("r2_mem_en", 32'(mem_en_o), 32'd1);
        check_eq("r2_rd_valid", 32'(rd_valid_o), 32'd0);
        next_cyc();
        @(negedge clk);
        check_eq("r3_mem_en", 32'(mem_en_o), 32'd1);
        check_eq("r3_rd_valid", 32'(rd_valid_o), 32'd1);
        check_eq("r3_rd_data", 32'(rd_data_o), 32'hAA);
        next_cyc();
        @(negedge clk);
        check_eq("rdrain_mem_en", 32'(mem_en_o), 32'd0);
        check_eq("rdrain_empty", 32'(empty_o), 32'd1);
        check_eq("rdrain_count", 32'(count_o), 32'd0);
        check_eq("rdrain_rd_data", 32'(rd_data_o), 32'hBB);
        next_cyc();
        @(negedge clk);
        check_eq("r_last_rd_valid", 32'(rd_valid_o), 32'd1);
        check_eq("r_last_rd_data", 32'(rd_data_o), 32'hCC);
        check_eq("r_last_mem_en", 32'(mem_en_o), 32'd0);

        // Read request while empty: nothing happens.
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            @(negedge clk);
            check_eq("empty_rd_mem_en", 32'(mem_en_o), 32'd0);
            check_eq("empty_rd_valid", 32'(rd_valid_o), 32'd0);
        end
        next_cyc(); rd_req_i = 1'b0;

        // Fill to capacity with 20 offered bytes: bursts of 8 and 8.
        do_reset();
        track_clear();
        sent = 0; viol = 0;
        wr_valid_i = 1'b1; wr_data_i = 8'h00;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            w = mem_en_o && !tx_oe_o;
            if (w && count_o == 5'd16) viol++;
            if (w) sent++;
            track(w, 1'b0);
            next_cyc();
            if (w) wr_data_i = wr_data_i + 8'd1;
            wr_valid_i = (sent < 20);
        end
        @(negedge clk);
        check_eq("fill_accepted", 32'(sent), 32'd16);
        check_eq("fill_count", 32'(count_o), 32'd16);
        check_eq("fill_full", 32'(full_o), 32'd1);
        check_eq("fill_wr_ready", 32'(wr_ready_o), 32'd0);
        check_eq("fill_over_full", 32'(viol), 32'd0);
        check_eq("fill_nruns", 32'(nruns), 32'd2);
        check_eq("fill_burst0", 32'(run_len[0]), 32'd8);
        check_eq("fill_burst1", 32'(run_len[1]), 32'd8);
        next_cyc(); wr_valid_i = 1'b0;

        // Contention: preload 5, read 1 (count 4, last served READ), then both.
        do_reset();
        exp_q.delete();
        mon_en = 1'b1;
        acc = 0; wr_valid_i = 1'b1; wr_data_i = 8'h40;
        for (int c = 0; c < 40 && acc < 5; c++) begin
            @(negedge clk);
            w = mem_en_o && !tx_oe_o;
            if (w) acc++;
            next_cyc();
            if (w) wr_data_i = wr_data_i + 8'd1;
            if (acc == 5) wr_valid_i = 1'b0;
        end
        repeat (3) next_cyc();
        rd_req_i = 1'b1; acc = 0;
        for (int c = 0; c < 20 && acc < 1; c++) begin
            @(negedge clk);
            r = mem_en_o && tx_oe_o;
            if (r) acc++;
            next_cyc();
            if (acc == 1) rd_req_i = 1'b0;
        end
        repeat (4) next_cyc();
        @(negedge clk);
        check_eq("pre_count", 32'(count_o), 32'd4);
        next_cyc();
        track_clear();
        viol = 0; cyc = 0; last_rd_cyc = -100;
        wr_valid_i = 1'b1; rd_req_i = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            w = mem_en_o && !tx_oe_o;
            r = mem_en_o && tx_oe_o;
            if (r) last_rd_cyc = cyc;
            if (!tx_oe_o && (cyc - last_rd_cyc) < 3) viol++;
            track(w, r);
            cyc++;
            next_cyc();
            if (w) wr_data_i = wr_data_i + 8'd1;
        end
        wr_valid_i = 1'b0; rd_req_i = 1'b0;
        repeat (8) next_cyc();
        @(negedge clk);
        check_eq("alt_turnaround_viol", 32'(viol), 32'd0);
        check_eq("alt_run0_is_write", 32'(run_w[0]), 32'd1);
        check_eq("alt_run0_len", 32'(run_len[0]), 32'd8);
        check_eq("alt_run1_is_write", 32'(run_w[1]), 32'd0);
        check_eq("alt_run1_len", 32'(run_len[1]), 32'd8);
        check_eq("alt_run2_is_write", 32'(run_w[2]), 32'd1);
        check_eq("alt_run2_len", 32'(run_len[2]), 32'd8);
        check_eq("alt_run3_is_write", 32'(run_w[3]), 32'd0);
        check_eq("alt_sb_level", 32'(exp_q.size()), 32'(count_o));
        mon_en = 1'b0;
        next_cyc();

        // Reset in the middle of a write burst.
        do_reset();
        acc = 0; wr_valid_i = 1'b1; wr_data_i = 8'h30;
        for (int c = 0; c < 20 && acc < 5; c++) begin
            @(negedge clk);
            w = mem_en_o && !tx_oe_o;
            if (w) acc++;
            next_cyc();
            if (w) wr_data_i = wr_data_i + 8'd1;
        end
        rst_i = 1'b1;
        @(negedge clk);
        check_eq("mid_count", 32'(count_o), 32'd5);
        check_eq("mid_in_flight", 32'(mem_en_o), 32'd1);
        next_cyc(); rst_i = 1'b0;
        @(negedge clk);
        check_eq("mrst_tx_oe", 32'(tx_oe_o), 32'd1);
        check_eq("mrst_count", 32'(count_o), 32'd0);
        check_eq("mrst_mem_en", 32'(mem_en_o), 32'd0);
        check_eq("mrst_wr_ready", 32'(wr_ready_o), 32'd0);
        check_eq("mrst_bus_released", 32'(data_io), 32'h5A);
        next_cyc();
        @(negedge clk);
        check_eq("mrst_regrant_tx_oe", 32'(tx_oe_o), 32'd0);
        check_eq("mrst_regrant_count", 32'(count_o), 32'd0);
        next_cyc(); wr_valid_i = 1'b0;
        repeat (3) next_cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
